// File: rtl/my9262_rx.sv
// MY9262 serial receiver: deserialises DI into 16-bit words and decodes latch commands.
// Optional GCK edge monitor is enabled by defining MY9262_RX_GCK_MON_EN.
module my9262_rx #(
  parameter int SYNC_STAGES = 0,
  parameter int GLB_LAT_MIN = 3,
  parameter int MAX_BITS    = 1023
) (
  input  logic        CLK_60M,
  input  logic        RST_N,
  input  logic        my9262_Lat,
  input  logic        my9262_Dclk,
  input  logic        my9262_Di,
  input  logic        my9262_Gck,
  output logic [15:0] rx_word,
  output logic        rx_word_valid,
  output logic [1:0]  rx_cmd,
  output logic        rx_cmd_valid,
  output logic [9:0]  rx_frame_bits,
  output logic        rx_err,
  output logic        rx_busy,
  output logic [15:0] gck_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, REPORT} state_t;

  localparam logic [9:0] MAX_CNT = 10'(MAX_BITS);

`ifdef MY9262_RX_GCK_MON_EN
  localparam int IN_W = 4;
`else
  localparam int IN_W = 3;
`endif

  logic [IN_W-1:0] in_vec;
  logic [IN_W-1:0] smp;

`ifdef MY9262_RX_GCK_MON_EN
  assign in_vec = {my9262_Gck, my9262_Di, my9262_Dclk, my9262_Lat};
`else
  assign in_vec = {my9262_Di, my9262_Dclk, my9262_Lat};
`endif

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign smp = in_vec;
    end else begin : g_sync
      logic [IN_W-1:0] chain_reg [SYNC_STAGES];
      always_ff @(posedge CLK_60M or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < SYNC_STAGES; i++) chain_reg[i] <= '0;
        end else begin
          chain_reg[0] <= in_vec;
          for (int i = 1; i < SYNC_STAGES; i++) chain_reg[i] <= chain_reg[i-1];
        end
      end
      assign smp = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic lat_prev_reg, dclk_prev_reg;
  logic lat_rise, lat_fall, dclk_rise, di;

  assign lat_rise  = smp[0] & ~lat_prev_reg;
  assign lat_fall  = ~smp[0] & lat_prev_reg;
  assign dclk_rise = smp[1] & ~dclk_prev_reg;
  assign di        = smp[2];

  state_t state_reg, state_next;

  always_ff @(posedge CLK_60M or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (lat_rise) state_next = LATCH;
               else if (dclk_rise) state_next = SHIFT;
      SHIFT:   if (lat_rise) state_next = LATCH;
      LATCH:   if (lat_fall) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic        in_report, shift_en, is_glb;
  logic [15:0] shift_reg;
  logic [9:0]  bit_cnt_reg;
  logic [3:0]  word_bit_reg, lat_edges_reg;
  logic        word_done_reg;

  assign in_report = (state_reg == REPORT);
  assign shift_en  = dclk_rise && !in_report;
  assign is_glb    = {28'd0, lat_edges_reg} >= 32'(GLB_LAT_MIN);

  always_ff @(posedge CLK_60M or negedge RST_N) begin
    if (!RST_N) begin
      lat_prev_reg  <= 1'b0;
      dclk_prev_reg <= 1'b0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      word_bit_reg  <= '0;
      lat_edges_reg <= '0;
      word_done_reg <= 1'b0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_cmd        <= '0;
      rx_cmd_valid  <= 1'b0;
      rx_frame_bits <= '0;
      rx_err        <= 1'b0;
    end else begin
      lat_prev_reg  <= smp[0];
      dclk_prev_reg <= smp[1];
      word_done_reg <= shift_en && (word_bit_reg == 4'd15);
      rx_word_valid <= word_done_reg;
      rx_cmd_valid  <= in_report;
      if (in_report) begin
        rx_cmd        <= is_glb ? 2'd2 : 2'd1;
        rx_frame_bits <= bit_cnt_reg;
        // A LAT rise landing in the one-cycle REPORT window cannot be decoded
        if (bit_cnt_reg[3:0] != 4'd0 || bit_cnt_reg == MAX_CNT || lat_rise)
          rx_err <= 1'b1;
        shift_reg     <= '0;
        bit_cnt_reg   <= '0;
        word_bit_reg  <= '0;
        lat_edges_reg <= '0;
      end else if (shift_en) begin
        shift_reg    <= {shift_reg[14:0], di};
        word_bit_reg <= word_bit_reg + 4'd1;
        if (bit_cnt_reg != MAX_CNT) bit_cnt_reg <= bit_cnt_reg + 10'd1;
        if (state_reg == LATCH && lat_edges_reg != 4'd15)
          lat_edges_reg <= lat_edges_reg + 4'd1;
        if (word_bit_reg == 4'd15) rx_word <= {shift_reg[14:0], di};
      end
    end
  end

  assign rx_busy = (state_reg != IDLE);

`ifdef MY9262_RX_GCK_MON_EN
  logic gck_prev_reg, gck_rise;
  assign gck_rise = smp[3] & ~gck_prev_reg;

  always_ff @(posedge CLK_60M or negedge RST_N) begin
    if (!RST_N) begin
      gck_prev_reg <= 1'b0;
      gck_count    <= '0;
    end else begin
      gck_prev_reg <= smp[3];
      if (in_report && is_glb)
        gck_count <= gck_rise ? 16'd1 : 16'd0;
      else if (gck_rise && gck_count != 16'hFFFF)
        gck_count <= gck_count + 16'd1;
    end
  end
`else
  logic unused_gck;
  assign unused_gck = my9262_Gck;
  assign gck_count  = '0;
`endif

endmodule

// File: tb/tb_my9262_rx.sv
// Scoreboard bench for my9262_rx: directed frames push expected words/commands,
// a negedge monitor pops and compares on each valid pulse.
module tb_my9262_rx;

  logic        CLK_60M = 1'b0;
  logic        RST_N = 1'b0;
  logic        my9262_Lat = 1'b0;
  logic        my9262_Dclk = 1'b0;
  logic        my9262_Di = 1'b0;
  logic        my9262_Gck = 1'b0;
  logic [15:0] rx_word;
  logic        rx_word_valid;
  logic [1:0]  rx_cmd;
  logic        rx_cmd_valid;
  logic [9:0]  rx_frame_bits;
  logic        rx_err;
  logic        rx_busy;
  logic [15:0] gck_count;

  my9262_rx dut (
    .CLK_60M(CLK_60M), .RST_N(RST_N),
    .my9262_Lat(my9262_Lat), .my9262_Dclk(my9262_Dclk),
    .my9262_Di(my9262_Di), .my9262_Gck(my9262_Gck),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid),
    .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid),
    .rx_frame_bits(rx_frame_bits), .rx_err(rx_err),
    .rx_busy(rx_busy), .gck_count(gck_count)
  );

  always #8 CLK_60M = ~CLK_60M;

  typedef struct {
    logic [1:0] cmd;
    logic [9:0] fb;
    logic       err;
  } exp_cmd_t;

  logic [15:0] word_q[$];
  exp_cmd_t    cmd_q[$];
  logic        bit_q[$];
  int checks = 0;
  int errors = 0;

`ifdef MY9262_RX_GCK_MON_EN
  localparam bit GCK_ON = 1'b1;
`else
  localparam bit GCK_ON = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse pops one expected entry
  always @(negedge CLK_60M) begin
    if (RST_N) begin
      if (rx_word_valid) begin
        if (word_q.size() == 0) begin
          check("unexpected_word", 32'(rx_word), -1);
        end else begin
          logic [15:0] ew;
          ew = word_q.pop_front();
          check("rx_word", 32'(rx_word), 32'(ew));
          $display("word 0x%04h (expected 0x%04h)", rx_word, ew);
        end
      end
      if (rx_cmd_valid) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", 32'(rx_cmd), -1);
        end else begin
          exp_cmd_t ec;
          ec = cmd_q.pop_front();
          check("rx_cmd", 32'(rx_cmd), 32'(ec.cmd));
          check("rx_frame_bits", 32'(rx_frame_bits), 32'(ec.fb));
          check("rx_err", 32'(rx_err), 32'(ec.err));
          if (rx_cmd == 2'd2) check("gck_count_at_glb", 32'(gck_count), 0);
          $display("cmd %0d bits %0d err %0d", rx_cmd, rx_frame_bits, rx_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK_60M);
    #1;
  endtask

  task automatic send_bit(input logic b);
    my9262_Di = b;
    my9262_Dclk = 1'b1;
    tick();
    my9262_Dclk = 1'b0;
    tick();
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bit_q.push_back(w[i]);
  endtask

  task automatic expect_cmd(input logic [1:0] c, input logic [9:0] fb, input logic e);
    exp_cmd_t ec;
    ec.cmd = c; ec.fb = fb; ec.err = e;
    cmd_q.push_back(ec);
  endtask

  // LAT rises before the last nlat bits; nlat=0 gives an empty LAT pulse after the data.
  // coinc puts the final DCLK rise in the same cycle as the LAT fall.
  task automatic send_frame(input int nlat, input bit coinc);
    int n;
    n = bit_q.size();
    for (int i = 0; i < n; i++) begin
      if (nlat > 0 && i == n - nlat) begin
        my9262_Lat = 1'b1;
        tick();
      end
      if (coinc && i == n - 1) begin
        my9262_Di = bit_q[i];
        my9262_Dclk = 1'b1;
        my9262_Lat = 1'b0;
        tick();
        my9262_Dclk = 1'b0;
        tick();
      end else begin
        send_bit(bit_q[i]);
      end
    end
    if (!coinc) begin
      if (nlat == 0) begin
        my9262_Lat = 1'b1;
        tick();
      end
      my9262_Lat = 1'b0;
      tick();
    end
    bit_q.delete();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (word_q.size() != 0 || cmd_q.size() != 0); i++) tick();
    tick();
    check({name, "_drained"}, word_q.size() + cmd_q.size(), 0);
    check({name, "_busy"}, 32'(rx_busy), 0);
  endtask

  task automatic gck_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      my9262_Gck = 1'b1;
      tick();
      my9262_Gck = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1;
    check("rst_word", 32'(rx_word), 0);
    check("rst_word_valid", 32'(rx_word_valid), 0);
    check("rst_cmd", 32'(rx_cmd), 0);
    check("rst_cmd_valid", 32'(rx_cmd_valid), 0);
    check("rst_frame_bits", 32'(rx_frame_bits), 0);
    check("rst_err", 32'(rx_err), 0);
    check("rst_busy", 32'(rx_busy), 0);
    check("rst_gck", 32'(gck_count), 0);
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (3) tick();

    // Single word, 1-edge data latch
    push_word(16'h0064);
    word_q.push_back(16'h0064);
    expect_cmd(2'd1, 10'd16, 1'b0);
    send_frame(1, 1'b0);
    drain("t1");

    // 512 bits, global latch over the last 3 rises
    push_word(16'h0064);
    word_q.push_back(16'h0064);
    for (int k = 0; k < 31; k++) begin
      push_word(16'hFFFF);
      word_q.push_back(16'hFFFF);
    end
    expect_cmd(2'd2, 10'd512, 1'b0);
    send_frame(3, 1'b0);
    drain("t2");

    // DCLK rise coincident with LAT fall is the third latch edge
    push_word(16'h00FF);
    word_q.push_back(16'h00FF);
    expect_cmd(2'd2, 10'd16, 1'b0);
    send_frame(3, 1'b1);
    drain("t4");

    // 20 bits, empty LAT pulse: trailing 4 bits dropped, error raised
    push_word(16'h1234);
    bit_q.push_back(1'b1); bit_q.push_back(1'b0);
    bit_q.push_back(1'b1); bit_q.push_back(1'b0);
    word_q.push_back(16'h1234);
    expect_cmd(2'd1, 10'd20, 1'b1);
    send_frame(0, 1'b0);
    drain("t3");
    repeat (10) tick();
    check("err_sticky", 32'(rx_err), 1);

    // Reset mid-frame after 9 bits
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    RST_N = 1'b0;
    #1;
    check("midrst_err", 32'(rx_err), 0);
    check("midrst_busy", 32'(rx_busy), 0);
    check("midrst_word", 32'(rx_word), 0);
    check("midrst_frame_bits", 32'(rx_frame_bits), 0);
    check("midrst_cmd", 32'(rx_cmd), 0);
    repeat (3) tick();
    RST_N = 1'b1;
    repeat (2) tick();
    push_word(16'hA5A5);
    word_q.push_back(16'hA5A5);
    expect_cmd(2'd1, 10'd16, 1'b0);
    send_frame(1, 1'b0);
    drain("t5");

    // GCK monitor: 100 periods, global latch, 5 periods
    gck_pulses(100);
    check("gck_100", 32'(gck_count), GCK_ON ? 100 : 0);
    push_word(16'h0F0F);
    word_q.push_back(16'h0F0F);
    expect_cmd(2'd2, 10'd16, 1'b0);
    send_frame(3, 1'b0);
    drain("t6");
    check("gck_after_glb", 32'(gck_count), 0);
    gck_pulses(5);
    check("gck_5", 32'(gck_count), GCK_ON ? 5 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
